select_action_param: RTL
========================

Name: select_action_param

Overview:
- Parametrised successor to the per-node routing action selector in the WSN Q-learning cluster datapath.
- Scans a vector of NUM_SINKS in-cluster sink candidates, then the best next hop, and picks one action with fixed priority: sink > nexthop > self.
- When the action is self (cluster-head role), writes the aggregation flag into node memory.
- Sits between the Q-table/neighbour logic that supplies the candidates and the reward/packet-forwarding stage that consumes action.

Parameters:
- WORD_WIDTH, 16, width of node IDs / action / memory data.
- ADDR_WIDTH, 11, node-memory address width.
- NUM_SINKS, 4, number of candidate sink slots (>=1).
- NULL_ID, 65, ID value meaning "no candidate".
- AGG_FLAG_ADDR, 2, memory address of the forAggregation flag.
- AGG_FLAG_VAL, 1, data written to AGG_FLAG_ADDR for self.

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  arm request; accepted in IDLE or DONE only
- start  in  1  begin selection; accepted in ARMED only
- nexthop  in  WORD_WIDTH  best-hop node ID, or NULL_ID
- nextsinks  in  NUM_SINKS*WORD_WIDTH  sink IDs, slot i at bits [i*WORD_WIDTH +: WORD_WIDTH], NULL_ID = empty
- epsilon  in  8  exploration threshold (present only with SELECT_ACTION_EXPLORE_EN)
- action  out  WORD_WIDTH  selected node ID
- action_src  out  2  0=self, 1=sink, 2=nexthop, 3=explore
- address  out  ADDR_WIDTH  memory write address
- data_out  out  WORD_WIDTH  memory write data
- wr_en  out  1  memory write strobe
- for_aggregation  out  1  action is self; aggregation scheduled
- done  out  1  selection complete; held until next accepted en

Behaviour:
- Outputs are registered. Reset values: done=0, wr_en=0, for_aggregation=0, address=0, data_out=0, action=NULL_ID, action_src=0, state=IDLE, scan index=0, best sink=NULL_ID.
- IDLE: en=1 clears every output to its reset value and moves to ARMED. start is ignored.
- ARMED: start=1 moves to SCAN with index=0. Otherwise stay in ARMED.
- SCAN, one slot per cycle:
  - If slot[index] != NULL_ID and best sink is still NULL_ID, latch slot[index]. The lowest-index valid slot wins.
  - After index NUM_SINKS-1, go to DECIDE. The index counter is clog2(NUM_SINKS) bits and is never allowed to wrap.
- DECIDE, first matching rule applies:
  - best sink valid: action=best sink, action_src=1.
  - else nexthop != NULL_ID: action=nexthop, action_src=2.
  - else: action=NULL_ID, action_src=0, for_aggregation=1, address=AGG_FLAG_ADDR, data_out=AGG_FLAG_VAL, wr_en=1.
  - Then go to WRITE.
- WRITE: wr_en=0, so the strobe is exactly one cycle wide. Go to DONE.
- DONE: done=1. action, action_src and for_aggregation hold. A new en clears them and moves to ARMED.
- Latency: done rises on the (NUM_SINKS+3)th rising edge after the edge that samples start in ARMED. This is 7 edges for NUM_SINKS=4.
- Input stability: nextsinks and nexthop must be stable from start until done. nexthop is sampled in DECIDE only.
- Ignored events: en while in ARMED/SCAN/DECIDE/WRITE. start outside ARMED.
- Simultaneous en and start in DONE: en is taken, start is ignored. start must be reasserted in ARMED.
- rst at any time, mid-scan included: immediate return to reset values. An in-flight wr_en is dropped asynchronously.
- No arithmetic is performed on IDs; comparisons are full WORD_WIDTH equality against NULL_ID.

Optional Feature:
- Macro: SELECT_ACTION_EXPLORE_EN.
- With the macro defined:
  - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5 on reset, advances every clock.
  - In DECIDE, if lfsr < epsilon and slot[lfsr mod NUM_SINKS] != NULL_ID, the block takes that slot as action with action_src=3. This overrides the priority rules and never writes the flag.
  - epsilon=0 disables exploration.
- Without the macro: no epsilon port, no LFSR, action_src never 3.

Decomposition:
- Shared package (select_action_pkg):
  - action_src encodings: SRC_SELF, SRC_SINK, SRC_NEXTHOP, SRC_EXPLORE.
  - state encoding: IDLE, ARMED, SCAN, DECIDE, WRITE, DONE.
  - default NULL_ID and AGG_FLAG_ADDR constants.
- One natural sub-module: action_lfsr8, the LFSR, instantiated only under SELECT_ACTION_EXPLORE_EN.

Test Plan:
- rst pulse mid-SCAN -> all outputs return to reset values at once (action=65); next en+start completes normally.
- NUM_SINKS=4, sinks={65,12,7,65}, nexthop=30, en then start -> done after 7 edges, action=12, action_src=1, wr_en never high.
- All sinks 65, nexthop=30 -> action=30, action_src=2, for_aggregation=0, no write.
- All sinks 65, nexthop=65 -> wr_en high exactly 1 cycle with address=2 and data_out=1; for_aggregation=1, action=65, action_src=0.
- en and start asserted together in DONE -> goes to ARMED only, done=0; start one cycle later -> second result correct.
- SELECT_ACTION_EXPLORE_EN, epsilon=255, sinks={3,4,5,6} -> action equals slot[lfsr mod 4] per reference model, action_src=3; epsilon=0 -> action=3, action_src=1.

Source files
------------

// File: rtl/select_action_pkg.sv
// Shared types and defaults for the routing action selector.
// Holds the action_src and FSM state encodings plus the LFSR step function.
package select_action_pkg;

  typedef enum logic [1:0] {
    SRC_SELF    = 2'd0,
    SRC_SINK    = 2'd1,
    SRC_NEXTHOP = 2'd2,
    SRC_EXPLORE = 2'd3
  } action_src_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    SCAN   = 3'd2,
    DECIDE = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam int DEFAULT_NULL_ID       = 65;
  localparam int DEFAULT_AGG_FLAG_ADDR = 2;
  localparam int DEFAULT_AGG_FLAG_VAL  = 1;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/action_lfsr8.sv
// Free-running 8-bit pseudo-random source used for exploratory action picks.
// Reseeds to LFSR_SEED on reset and advances on every clock.
module action_lfsr8
  import select_action_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr8_next(lfsr_q);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/select_action_param.sv
// Per-node routing action selector: sink > nexthop > self, with aggregation flag write on self.
// Optional epsilon-greedy exploration is enabled with the SELECT_ACTION_EXPLORE_EN macro.
module select_action_param
  import select_action_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 11,
  parameter int NUM_SINKS     = 4,
  parameter int NULL_ID       = DEFAULT_NULL_ID,
  parameter int AGG_FLAG_ADDR = DEFAULT_AGG_FLAG_ADDR,
  parameter int AGG_FLAG_VAL  = DEFAULT_AGG_FLAG_VAL
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            start,
  input  logic [WORD_WIDTH-1:0]           nexthop,
  input  logic [NUM_SINKS*WORD_WIDTH-1:0] nextsinks,
`ifdef SELECT_ACTION_EXPLORE_EN
  input  logic [7:0]                      epsilon,
`endif
  output logic [WORD_WIDTH-1:0]           action,
  output logic [1:0]                      action_src,
  output logic [ADDR_WIDTH-1:0]           address,
  output logic [WORD_WIDTH-1:0]           data_out,
  output logic                            wr_en,
  output logic                            for_aggregation,
  output logic                            done
);

  localparam int IDX_W = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_SINKS - 1);
  localparam logic [WORD_WIDTH-1:0] NULL_W   = WORD_WIDTH'(NULL_ID);
  localparam logic [ADDR_WIDTH-1:0] AGG_ADDR = ADDR_WIDTH'(AGG_FLAG_ADDR);
  localparam logic [WORD_WIDTH-1:0] AGG_VAL  = WORD_WIDTH'(AGG_FLAG_VAL);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_WIDTH-1:0]   best_q, best_d;
  logic [WORD_WIDTH-1:0]   action_q, action_d;
  action_src_e             src_q, src_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    agg_q, agg_d;
  logic                    done_q, done_d;
  logic                    clear_out;

  logic [WORD_WIDTH-1:0]   slots [NUM_SINKS];
  logic [WORD_WIDTH-1:0]   scan_slot;
  logic                    explore_hit;
  logic [WORD_WIDTH-1:0]   explore_slot;

  always_comb begin
    for (int i = 0; i < NUM_SINKS; i++) begin
      slots[i] = nextsinks[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign scan_slot = slots[idx_q];

`ifdef SELECT_ACTION_EXPLORE_EN
  logic [7:0]       lfsr;
  logic [IDX_W-1:0] explore_idx;

  action_lfsr8 u_lfsr (
    .clock (clock),
    .rst   (rst),
    .lfsr  (lfsr)
  );

  // epsilon=0 can never satisfy lfsr < epsilon, so exploration switches itself off
  always_comb begin
    explore_idx  = IDX_W'(32'(lfsr) % NUM_SINKS);
    explore_slot = slots[explore_idx];
    explore_hit  = (lfsr < epsilon) && (explore_slot != NULL_W);
  end
`else
  assign explore_hit  = 1'b0;
  assign explore_slot = NULL_W;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    best_d    = best_q;
    action_d  = action_q;
    src_d     = src_q;
    address_d = address_q;
    data_d    = data_q;
    wr_en_d   = wr_en_q;
    agg_d     = agg_q;
    done_d    = done_q;
    clear_out = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          clear_out = 1'b1;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (start) begin
          idx_d   = '0;
          best_d  = NULL_W;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if ((scan_slot != NULL_W) && (best_q == NULL_W)) begin
          best_d = scan_slot;
        end
        // index stops at the last slot instead of wrapping
        if (idx_q == LAST_IDX) begin
          state_d = DECIDE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DECIDE: begin
        if (explore_hit) begin
          action_d = explore_slot;
          src_d    = SRC_EXPLORE;
        end else if (best_q != NULL_W) begin
          action_d = best_q;
          src_d    = SRC_SINK;
        end else if (nexthop != NULL_W) begin
          action_d = nexthop;
          src_d    = SRC_NEXTHOP;
        end else begin
          action_d  = NULL_W;
          src_d     = SRC_SELF;
          agg_d     = 1'b1;
          address_d = AGG_ADDR;
          data_d    = AGG_VAL;
          wr_en_d   = 1'b1;
        end
        state_d = WRITE;
      end
      WRITE: begin
        wr_en_d = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        if (en) begin
          clear_out = 1'b1;
          state_d   = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear_out) begin
      action_d  = NULL_W;
      src_d     = SRC_SELF;
      address_d = '0;
      data_d    = '0;
      wr_en_d   = 1'b0;
      agg_d     = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      best_q    <= NULL_W;
      action_q  <= NULL_W;
      src_q     <= SRC_SELF;
      address_q <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      agg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      action_q  <= action_d;
      src_q     <= src_d;
      address_q <= address_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      agg_q     <= agg_d;
      done_q    <= done_d;
    end
  end

  assign action          = action_q;
  assign action_src      = src_q;
  assign address         = address_q;
  assign data_out        = data_q;
  assign wr_en           = wr_en_q;
  assign for_aggregation = agg_q;
  assign done            = done_q;

endmodule
